// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU: one operation in flight,
// registered operands and registered results handed back to the requester that issued it.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int RR_EN      = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s0_req_valid,
    output logic                  s0_req_ready,
    input  logic [OP_WIDTH-1:0]   s0_alu_op,
    input  logic [DATA_WIDTH-1:0] s0_a,
    input  logic [DATA_WIDTH-1:0] s0_b,
    output logic                  s0_rsp_valid,
    input  logic                  s0_rsp_ready,
    output logic [DATA_WIDTH-1:0] s0_result,
    output logic [2:0]            s0_flags,
    output logic                  s0_rsp_err,
    input  logic                  s1_req_valid,
    output logic                  s1_req_ready,
    input  logic [OP_WIDTH-1:0]   s1_alu_op,
    input  logic [DATA_WIDTH-1:0] s1_a,
    input  logic [DATA_WIDTH-1:0] s1_b,
    output logic                  s1_rsp_valid,
    input  logic                  s1_rsp_ready,
    output logic [DATA_WIDTH-1:0] s1_result,
    output logic [2:0]            s1_flags,
    output logic                  s1_rsp_err,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [OP_WIDTH-1:0]   alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,
    input  logic                  alu_Zero
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_id_q, gnt_id_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [2:0]            flags_q, flags_d;
    logic                  err_q, err_d;

    logic grant;
    logic req_any;
    logic handshake;
    logic rsp_taken;

    function automatic logic op_legal(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_WIDTH'(0), OP_WIDTH'(1), OP_WIDTH'(2), OP_WIDTH'(3),
            OP_WIDTH'(4), OP_WIDTH'(5), OP_WIDTH'(6), OP_WIDTH'(7),
            OP_WIDTH'(10), OP_WIDTH'(11), OP_WIDTH'(15): return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Ties go to the port opposite the last accepted one (round-robin) or to s0.
    always_comb begin
        req_any = s0_req_valid | s1_req_valid;
        if (s0_req_valid && s1_req_valid)
            grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
        else
            grant = s1_req_valid;
        handshake = (state_q == IDLE) && req_any;
        rsp_taken = gnt_id_q ? s1_rsp_ready : s0_rsp_ready;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        result_d     = result_q;
        flags_d      = flags_q;
        err_d        = err_q;
        case (state_q)
            IDLE: if (handshake) begin
                state_d      = EXEC;
                gnt_id_d     = grant;
                last_grant_d = grant;
                alu_op_d     = grant ? s1_alu_op : s0_alu_op;
                alu_a_d      = grant ? s1_a : s0_a;
                alu_b_d      = grant ? s1_b : s0_b;
            end
            EXEC: begin
                state_d  = RESP;
                result_d = alu_Result;
                flags_d  = {alu_Overflow, alu_CarryOut, alu_Zero};
                err_d    = ~op_legal(alu_op_q);
            end
            RESP: if (rsp_taken) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s0_req_ready = handshake && !grant;
        s1_req_ready = handshake && grant;
        s0_rsp_valid = (state_q == RESP) && !gnt_id_q;
        s1_rsp_valid = (state_q == RESP) && gnt_id_q;
    end

    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_ALUop  = alu_op_q;
    assign s0_result  = result_q;
    assign s1_result  = result_q;
    assign s0_flags   = flags_q;
    assign s1_flags   = flags_q;
    assign s0_rsp_err = err_q;
    assign s1_rsp_err = err_q;

endmodule
